// File: rtl/hash_lut_v2.sv
`default_nettype none
// ============================================================================
// Module   : hash_lut_v2
// Desc     : Bloom-filter bit-array LUT. There is one 2^HASH_W x 1 table for
//            each (string size, hash) pair. Port A serves the Avalon-MM
//            write/readback path and the clear engine; port B serves lookups.
//            Optional macro HASH_LUT_V2_OUT_REG_EN adds an output register
//            stage after the match AND.
// Revision : 1.0
// ============================================================================
module hash_lut_v2 #(
  parameter int AMM_LUT_ADDR_W = 32,
  parameter int AMM_LUT_DATA_W = 32,
  parameter int MAX_STR_SIZE   = 20,
  parameter int MIN_STR_SIZE   = 8,
  parameter int HASHES_CNT     = 6,
  parameter int HASH_W         = 12
) (
  input  logic                                                          clk_i,
  input  logic                                                          srst_i,
  input  logic                                                          config_i,
  input  logic [AMM_LUT_ADDR_W-1:0]                                     amm_slave_lut_address_i,
  input  logic                                                          amm_slave_lut_write_i,
  input  logic [AMM_LUT_DATA_W-1:0]                                     amm_slave_lut_writedata_i,
  input  logic                                                          amm_slave_lut_read_i,
  output logic [AMM_LUT_DATA_W-1:0]                                     amm_slave_lut_readdata_o,
  output logic                                                          amm_slave_lut_readdatavalid_o,
  output logic                                                          amm_slave_lut_waitrequest_o,
  input  logic                                                          clear_start_i,
  output logic                                                          clear_busy_o,
  input  logic                                                          lookup_valid_i,
  input  logic [MAX_STR_SIZE:MIN_STR_SIZE][HASHES_CNT-1:0][HASH_W-1:0]  lookup_address_i,
  output logic [MAX_STR_SIZE:MIN_STR_SIZE][HASHES_CNT-1:0]              lookup_bits_o,
  output logic [MAX_STR_SIZE:MIN_STR_SIZE]                              match_o,
  output logic                                                          match_valid_o
);

  localparam int STR_CNT    = MAX_STR_SIZE - MIN_STR_SIZE + 1;
  localparam int TABLES_CNT = STR_CNT * HASHES_CNT;
  localparam int TBL_W      = $clog2(TABLES_CNT);
  localparam int TBL_PAD    = 2 ** TBL_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic [HASH_W-1:0]   r_clr_cnt;
  logic                r_busy;
  logic                r_waitreq;

  logic [TBL_W-1:0]    w_tbl;
  logic [HASH_W-1:0]   w_bit;
  logic                w_cfg_ok;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_lk_acc;
  logic                w_clearing;
  logic                w_a_we;
  logic [HASH_W-1:0]   w_a_addr;
  logic                w_a_din;
  logic                w_unused;

  logic [TBL_PAD-1:0]                               w_qa;
  logic [MAX_STR_SIZE:MIN_STR_SIZE][HASHES_CNT-1:0] w_qb;
  logic [MAX_STR_SIZE:MIN_STR_SIZE]                 w_and;

  assign w_tbl      = amm_slave_lut_address_i[HASH_W+TBL_W-1:HASH_W];
  assign w_bit      = amm_slave_lut_address_i[HASH_W-1:0];
  assign w_clearing = (r_state == ST_CLEAR);

  assign w_cfg_ok = config_i && (r_state == ST_IDLE) && !r_waitreq;
  assign w_wr_acc = w_cfg_ok && amm_slave_lut_write_i;
  assign w_rd_acc = w_cfg_ok && amm_slave_lut_read_i && !amm_slave_lut_write_i;
  assign w_lk_acc = lookup_valid_i && !config_i && (r_state == ST_IDLE);

  // Reset blocks every port-A write so a clear interrupted by srst_i stops exactly
  // at the current counter address.
  assign w_a_we   = !srst_i && (w_clearing || w_wr_acc);
  assign w_a_addr = w_clearing ? r_clr_cnt : w_bit;
  assign w_a_din  = w_clearing ? 1'b0 : amm_slave_lut_writedata_i[0];

  assign w_unused = ^{amm_slave_lut_address_i[AMM_LUT_ADDR_W-1:HASH_W+TBL_W],
                      amm_slave_lut_writedata_i[AMM_LUT_DATA_W-1:1]};

  // -------------------------------------------------------------------------
  // Control FSM: the clear engine
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
      r_busy    <= 1'b0;
      r_waitreq <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clear_start_i && config_i) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
            r_waitreq <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + HASH_W'(1);
          if (r_clr_cnt == {HASH_W{1'b1}}) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_waitreq <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign clear_busy_o                = r_busy;
  assign amm_slave_lut_waitrequest_o = r_waitreq;

  // -------------------------------------------------------------------------
  // Bit tables. A table that does not exist never matches w_tbl, so writes to
  // it are dropped and its padded readback slot reads 0.
  // -------------------------------------------------------------------------
  for (genvar gs = MIN_STR_SIZE; gs <= MAX_STR_SIZE; gs++) begin : g_str
    for (genvar gh = 0; gh < HASHES_CNT; gh++) begin : g_hash
      localparam logic [TBL_W-1:0] c_TBL_IDX = TBL_W'((gs - MIN_STR_SIZE) * HASHES_CNT + gh);

      logic r_mem [2**HASH_W];
      logic r_qa;
      logic r_qb;

      always_ff @(posedge clk_i) begin
        if (w_a_we && (w_clearing || (w_tbl == c_TBL_IDX))) begin
          r_mem[w_a_addr] <= w_a_din;
        end
        r_qa <= r_mem[w_a_addr];
        r_qb <= r_mem[lookup_address_i[gs][gh]];
      end

      assign w_qa[c_TBL_IDX] = r_qa;
      assign w_qb[gs][gh]    = r_qb;
    end
    assign w_and[gs] = &w_qb[gs];
  end

  if (TABLES_CNT < TBL_PAD) begin : g_pad
    assign w_qa[TBL_PAD-1:TABLES_CNT] = '0;
  end

  // -------------------------------------------------------------------------
  // Readback pipeline: table read at the accept edge, table select one later
  // -------------------------------------------------------------------------
  logic                      r_rd_v1;
  logic [TBL_W-1:0]          r_rd_tbl;
  logic                      r_rdv;
  logic [AMM_LUT_DATA_W-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_rd_v1  <= 1'b0;
      r_rd_tbl <= '0;
      r_rdv    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rd_v1  <= w_rd_acc;
      r_rd_tbl <= w_tbl;
      r_rdv    <= r_rd_v1;
      if (r_rd_v1) begin
        r_rdata <= AMM_LUT_DATA_W'(w_qa[r_rd_tbl]);
      end
    end
  end

  assign amm_slave_lut_readdata_o      = r_rdata;
  assign amm_slave_lut_readdatavalid_o = r_rdv;

  // -------------------------------------------------------------------------
  // Lookup pipeline
  // -------------------------------------------------------------------------
  logic                                             r_lk_v1;
  logic                                             r_lk_v2;
  logic [MAX_STR_SIZE:MIN_STR_SIZE][HASHES_CNT-1:0] r_bits2;
  logic [MAX_STR_SIZE:MIN_STR_SIZE]                 r_match2;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_lk_v1  <= 1'b0;
      r_lk_v2  <= 1'b0;
      r_bits2  <= '0;
      r_match2 <= '0;
    end else begin
      r_lk_v1 <= w_lk_acc;
      r_lk_v2 <= r_lk_v1;
      if (r_lk_v1) begin
        r_bits2  <= w_qb;
        r_match2 <= w_and;
      end
    end
  end

`ifdef HASH_LUT_V2_OUT_REG_EN
  logic                                             r_lk_v3;
  logic [MAX_STR_SIZE:MIN_STR_SIZE][HASHES_CNT-1:0] r_bits3;
  logic [MAX_STR_SIZE:MIN_STR_SIZE]                 r_match3;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_lk_v3  <= 1'b0;
      r_bits3  <= '0;
      r_match3 <= '0;
    end else begin
      r_lk_v3 <= r_lk_v2;
      if (r_lk_v2) begin
        r_bits3  <= r_bits2;
        r_match3 <= r_match2;
      end
    end
  end

  assign lookup_bits_o = r_bits3;
  assign match_o       = r_match3;
  assign match_valid_o = r_lk_v3;
`else
  assign lookup_bits_o = r_bits2;
  assign match_o       = r_match2;
  assign match_valid_o = r_lk_v2;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hash_lut_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_hash_lut_v2
// Desc     : Self-checking bench for hash_lut_v2 against a bit-array model.
//            Honours HASH_LUT_V2_OUT_REG_EN for the lookup latency.
// Revision : 1.0
// ============================================================================
module tb_hash_lut_v2;

  localparam int MIN   = 8;
  localparam int MAX   = 20;
  localparam int HC    = 6;
  localparam int HW    = 12;
  localparam int TC    = (MAX - MIN + 1) * HC;
  localparam int DEPTH = 2 ** HW;
`ifdef HASH_LUT_V2_OUT_REG_EN
  localparam int LK_LAT = 3;
`else
  localparam int LK_LAT = 2;
`endif

  typedef logic [MAX:MIN][HC-1:0][HW-1:0] lk_addr_t;
  typedef logic [MAX:MIN][HC-1:0]         lk_bits_t;
  typedef logic [MAX:MIN]                 lk_match_t;
  typedef struct packed {
    logic      v;
    lk_bits_t  b;
    lk_match_t m;
  } lk_exp_t;

  logic        clk = 1'b0;
  logic        srst, cfg, wr, rd, clr, lk_v;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        rdv, waitreq, busy, mv;
  lk_addr_t    lk_addr;
  lk_bits_t    bits;
  lk_match_t   match;

  hash_lut_v2 dut (
    .clk_i                         (clk),
    .srst_i                        (srst),
    .config_i                      (cfg),
    .amm_slave_lut_address_i       (addr),
    .amm_slave_lut_write_i         (wr),
    .amm_slave_lut_writedata_i     (wdata),
    .amm_slave_lut_read_i          (rd),
    .amm_slave_lut_readdata_o      (rdata),
    .amm_slave_lut_readdatavalid_o (rdv),
    .amm_slave_lut_waitrequest_o   (waitreq),
    .clear_start_i                 (clr),
    .clear_busy_o                  (busy),
    .lookup_valid_i                (lk_v),
    .lookup_address_i              (lk_addr),
    .lookup_bits_o                 (bits),
    .match_o                       (match),
    .match_valid_o                 (mv)
  );

  always #5 clk = ~clk;

  bit ref_mem [TC][DEPTH];
  int n_cmp = 0;
  int n_err = 0;
  logic [HW-1:0] key [MAX:MIN];

  task automatic chk_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_addr(input int t, input int b);
    return (32'(t) << HW) | 32'(b & (DEPTH - 1));
  endfunction

  task automatic amm_write(input int t, input int b, input bit v);
    addr  = mk_addr(t, b);
    wdata = $urandom();
    wdata[0] = v;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    if (t < TC) ref_mem[t][b] = v;
  endtask

  task automatic amm_read(input int t, input int b, input string tag);
    bit e;
    e = 1'b0;
    if (t < TC) e = ref_mem[t][b];
    addr = mk_addr(t, b);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    chk_val({tag, "_rdv_early"}, rdv, 0);
    @(negedge clk);
    chk_val({tag, "_rdv"}, rdv, 1);
    chk_val({tag, "_data"}, rdata, 128'(e));
    @(negedge clk);
    chk_val({tag, "_rdv_pulse"}, rdv, 0);
  endtask

  task automatic exp_lookup(input lk_addr_t a, output lk_bits_t eb, output lk_match_t em);
    for (int s = MIN; s <= MAX; s++) begin
      em[s] = 1'b1;
      for (int h = 0; h < HC; h++) begin
        eb[s][h] = ref_mem[(s - MIN) * HC + h][a[s][h]];
        em[s]    = em[s] & eb[s][h];
      end
    end
  endtask

  task automatic lookup_once(input lk_addr_t a, input string tag);
    lk_bits_t  eb;
    lk_match_t em;
    exp_lookup(a, eb, em);
    lk_addr = a;
    lk_v = 1'b1;
    @(negedge clk);
    lk_v = 1'b0;
    for (int k = 1; k < LK_LAT; k++) begin
      chk_val({tag, "_mv_early"}, mv, 0);
      @(negedge clk);
    end
    chk_val({tag, "_mv"}, mv, 1);
    chk_val({tag, "_bits"}, bits, eb);
    chk_val({tag, "_match"}, match, em);
    @(negedge clk);
    chk_val({tag, "_mv_pulse"}, mv, 0);
  endtask

  task automatic run_clear(input string tag);
    int  cnt;
    int  wq_bad;
    int  rdv_seen;
    bit  done;
    cnt = 0; wq_bad = 0; rdv_seen = 0; done = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    while (!done && cnt < 5000) begin
      if (busy !== 1'b1) begin
        done = 1'b1;
      end else begin
        if (waitreq !== 1'b1) wq_bad++;
        if (rdv === 1'b1) rdv_seen++;
        cnt++;
        // Restart, write and read attempts mid-clear must all be ignored
        if (cnt == 10) begin
          clr = 1'b1; addr = mk_addr(0, 7); wdata = 32'h1; wr = 1'b1;
        end else if (cnt == 11) begin
          clr = 1'b0; wr = 1'b0; rd = 1'b1;
        end else begin
          rd = 1'b0;
        end
        @(negedge clk);
      end
    end
    chk_val({tag, "_busy_cycles"}, cnt, DEPTH);
    chk_val({tag, "_waitreq_track"}, wq_bad, 0);
    chk_val({tag, "_waitreq_drop"}, waitreq, 0);
    chk_val({tag, "_no_rdv"}, rdv_seen, 0);
    for (int t = 0; t < TC; t++)
      for (int b = 0; b < DEPTH; b++) ref_mem[t][b] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lk_exp_t  q[$];
    lk_addr_t a;
    int       set_t[$];
    int       set_b[$];
    bit       seen;
    int       last_t, last_b;

    srst = 1'b1; cfg = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; lk_v = 1'b0;
    addr = '0; wdata = '0; lk_addr = '0;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    chk_val("rst_busy", busy, 0);
    chk_val("rst_waitreq", waitreq, 0);
    chk_val("rst_rdv", rdv, 0);
    chk_val("rst_rdata", rdata, 0);
    chk_val("rst_mv", mv, 0);
    chk_val("rst_match", match, 0);
    chk_val("rst_bits", bits, 0);

    run_clear("clr0");
    amm_read(0, 7, "clr0_write_ignored");
    amm_read(0, 5, "rb_t0_b5");

    amm_write(3, 'h0A5, 1'b1);
    amm_read(3, 'h0A5, "rb_t3");
    amm_read(TC, 'h0A5, "rb_oob");

    // Simultaneous write and read: write lands, read vanishes
    addr = mk_addr(5, 'h77); wdata = 32'h1; wr = 1'b1; rd = 1'b1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    ref_mem[5]['h77] = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rdv === 1'b1) seen = 1'b1;
    end
    chk_val("wr_rd_no_rdv", seen, 0);
    amm_read(5, 'h77, "wr_rd_applied");

    last_t = 3; last_b = 'h0A5;
    for (int i = 0; i < 150; i++) begin
      int op, t, b;
      op = $urandom_range(0, 2);
      t  = ($urandom_range(0, 9) == 0) ? $urandom_range(TC, 127) : $urandom_range(0, TC - 1);
      b  = $urandom_range(0, DEPTH - 1);
      if (op == 0) begin
        amm_write(t, b, 1'($urandom_range(0, 1)));
        last_t = t; last_b = b;
      end else if (op == 1) begin
        amm_read(last_t, last_b, "rnd_rb_last");
      end else begin
        amm_read(t, b, "rnd_rb");
      end
    end

    for (int h = 0; h < HC; h++) amm_write(h, 'h123, 1'b1);
    amm_write(2, 'h124, 1'b0);
    for (int s = MIN; s <= MAX; s++) begin
      key[s] = HW'($urandom());
      for (int h = 0; h < HC; h++) amm_write((s - MIN) * HC + h, int'(key[s]), 1'b1);
    end

    cfg = 1'b0;
    for (int s = MIN; s <= MAX; s++)
      for (int h = 0; h < HC; h++) a[s][h] = (s == MIN) ? HW'('h123) : HW'($urandom());
    lookup_once(a, "lk_str8_hit");
    chk_val("lk_str8_match_bit", match[MIN], 1);
    a[MIN][2] = HW'('h124);
    lookup_once(a, "lk_str8_miss");
    chk_val("lk_str8_nomatch_bit", match[MIN], 0);

    // Lookups already in flight survive config_i rising; later ones are dropped
    begin
      lk_bits_t  eb;
      lk_match_t em;
      for (int s = MIN; s <= MAX; s++)
        for (int h = 0; h < HC; h++) a[s][h] = key[s];
      exp_lookup(a, eb, em);
      lk_addr = a; lk_v = 1'b1;
      @(negedge clk);
      cfg = 1'b1;
      @(negedge clk);
      lk_v = 1'b0;
      repeat (LK_LAT - 2) @(negedge clk);
      chk_val("inflight_mv", mv, 1);
      chk_val("inflight_match", match, em);
      @(negedge clk);
      chk_val("cfg_suppress_mv", mv, 0);
    end

    lk_v = 1'b1;
    seen = 1'b0;
    repeat (LK_LAT + 3) begin
      @(negedge clk);
      if (mv === 1'b1) seen = 1'b1;
    end
    lk_v = 1'b0;
    chk_val("lk_cfg1_no_mv", seen, 0);

    cfg = 1'b0;
    for (int k = 0; k < LK_LAT; k++) q.push_back('0);
    for (int c = 0; c < 300 + LK_LAT; c++) begin
      lk_exp_t e, cur;
      e = q.pop_front();
      chk_val("lk_pipe_mv", mv, e.v);
      if (e.v) begin
        chk_val("lk_pipe_bits", bits, e.b);
        chk_val("lk_pipe_match", match, e.m);
      end
      cur.v = (c < 300) && ($urandom_range(0, 3) != 0);
      for (int s = MIN; s <= MAX; s++) begin
        int m;
        m = $urandom_range(0, 3);
        for (int h = 0; h < HC; h++) begin
          if (m == 0) a[s][h] = key[s];
          else if (m == 1) a[s][h] = (h == $urandom_range(0, HC - 1)) ? HW'(key[s] + 1) : key[s];
          else a[s][h] = HW'($urandom());
        end
      end
      exp_lookup(a, cur.b, cur.m);
      lk_addr = a;
      lk_v = cur.v;
      q.push_back(cur);
      @(negedge clk);
    end
    lk_v = 1'b0;

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk_val("clr_cfg0_ignored", busy, 0);
    cfg = 1'b1;

    for (int t = 0; t < TC && set_t.size() < 16; t += 5)
      for (int b = 0; b < DEPTH && set_t.size() < 16; b++)
        if (ref_mem[t][b]) begin set_t.push_back(t); set_b.push_back(b); end
    run_clear("clr1");
    foreach (set_t[i]) amm_read(set_t[i], set_b[i], "clr1_wiped");

    // srst_i when the clear counter has reached 100
    foreach (set_t[i]) begin end
    for (int t = 0; t < TC; t += 40) begin
      amm_write(t, 50, 1'b1);
      amm_write(t, 99, 1'b1);
      amm_write(t, 100, 1'b1);
      amm_write(t, 150, 1'b1);
      amm_write(t, 3000, 1'b1);
    end
    amm_write(77, 100, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (100) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    chk_val("srst_busy", busy, 0);
    chk_val("srst_waitreq", waitreq, 0);
    chk_val("srst_rdv", rdv, 0);
    chk_val("srst_mv", mv, 0);
    srst = 1'b0;
    for (int t = 0; t < TC; t++)
      for (int b = 0; b < 100; b++) ref_mem[t][b] = 1'b0;
    amm_read(0, 50, "part_clr_50");
    amm_read(40, 99, "part_clr_99");
    amm_read(77, 100, "part_clr_100");
    amm_read(0, 150, "part_clr_150");
    amm_read(40, 3000, "part_clr_3000");

    addr = mk_addr(0, 150); rd = 1'b1;
    @(negedge clk);
    rd = 1'b0; srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    chk_val("rd_discard_a", rdv, 0);
    @(negedge clk);
    chk_val("rd_discard_b", rdv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hash_lut_v2.md
# hash_lut_v2

Second-generation Bloom-filter bit-array LUT: one 2^HASH_W x 1 table per (string size, hash) pair, filled over an Avalon-MM configuration slave and looked up by the hash stage in parallel. Over the first generation it adds:
- Avalon-MM readback with `readdatavalid`;
- a hardware clear engine;
- a valid-qualified lookup pipeline that ANDs all hash bits per string size into a match flag.

It sits between the hash calculators and the match collector in the bloom filter datapath.

## Interface
- `AMM_LUT_ADDR_W`, 32, config address width; must be ≥ TBL_W + HASH_W.
- `AMM_LUT_DATA_W`, 32, config data width; only bit 0 is significant.
- `MAX_STR_SIZE`, 20, largest string size.
- `MIN_STR_SIZE`, 8, smallest string size.
- `HASHES_CNT`, 6, hashes per string size.
- `HASH_W`, 12, hash width; table depth is 2^HASH_W.
- Derived values:
  - STR_CNT = MAX_STR_SIZE-MIN_STR_SIZE+1
  - TABLES_CNT = STR_CNT*HASHES_CNT
  - TBL_W = $clog2(TABLES_CNT)

Ports:
- `clk_i`  in  1  sole clock.
- `srst_i`  in  1  synchronous, active-high reset.
- `config_i`  in  1  1 = configuration mode, 0 = lookup mode.
- `amm_slave_lut_address_i`  in  AMM_LUT_ADDR_W  {table index, bit index}; bit index is [HASH_W-1:0], table index is [HASH_W+TBL_W-1:HASH_W].
- `amm_slave_lut_write_i`  in  1  write strobe.
- `amm_slave_lut_writedata_i`  in  AMM_LUT_DATA_W  bit 0 is the written value.
- `amm_slave_lut_read_i`  in  1  read strobe.
- `amm_slave_lut_readdata_o`  out  AMM_LUT_DATA_W  zero-extended table bit.
- `amm_slave_lut_readdatavalid_o`  out  1  readback valid.
- `amm_slave_lut_waitrequest_o`  out  1  high while clearing.
- `clear_start_i`  in  1  single-cycle request to zero all tables.
- `clear_busy_o`  out  1  clear engine active.
- `lookup_valid_i`  in  1  lookup addresses valid.
- `lookup_address_i`  in  [MAX_STR_SIZE:MIN_STR_SIZE][HASHES_CNT-1:0][HASH_W-1:0]  hash values.
- `lookup_bits_o`  out  [MAX_STR_SIZE:MIN_STR_SIZE][HASHES_CNT-1:0]  raw table bits.
- `match_o`  out  [MAX_STR_SIZE:MIN_STR_SIZE]  AND of that size's HASHES_CNT bits.
- `match_valid_o`  out  1  qualifies `lookup_bits_o` and `match_o`.

## Operation
- Each table is a true dual-port RAM.
  - Port A serves write, readback and clear.
  - Port B serves lookup.
  - Table index t maps to str size MIN_STR_SIZE + t/HASHES_CNT, hash t%HASHES_CNT.
- Control FSM states: IDLE, CLEAR.
  - IDLE→CLEAR on `clear_start_i`=1 with `config_i`=1. The clear counter loads 0.
  - In CLEAR every table writes 0 at the counter address and the counter increments each cycle.
  - CLEAR→IDLE after address 2^HASH_W-1 is written.
  - `clear_start_i` is ignored in CLEAR and when `config_i`=0.
- Write: accepted in IDLE with `config_i`=1 and waitrequest=0. Writes writedata[0] to table t at the bit index.
  - t ≥ TABLES_CNT: write dropped.
- Read: accepted under the same conditions as write.
  - t ≥ TABLES_CNT returns 0, still with readdatavalid.
- Write and read in the same cycle: write wins; the read is dropped and produces no readdatavalid.
- Write or read with `config_i`=0: ignored, and no readdatavalid is produced.
- Lookup: `lookup_valid_i` is sampled only when `config_i`=0 and FSM=IDLE; otherwise it is treated as 0.
  - `match_o[s]` = &`lookup_bits_o[s]`.
- Memory contents are not reset by `srst_i`.

## Timing
- Reset values:
  - FSM is IDLE and the clear counter is 0.
  - `clear_busy_o`, `amm_slave_lut_waitrequest_o`, `amm_slave_lut_readdatavalid_o` and `match_valid_o` are 0.
  - `amm_slave_lut_readdata_o`, `lookup_bits_o` and `match_o` are 0.
- Write takes effect at the next edge. A read to the same address issued the following cycle returns the new value.
- Readback latency is 2: read accepted at cycle N gives `readdatavalid`=1 for one cycle at N+2, with data. `readdata` holds its value otherwise.
- Lookup latency is 2 (3 with the macro below): `lookup_valid_i` at N gives `match_valid_o` at N+2. Fully pipelined, one lookup per cycle.
- Clear:
  - `clear_start_i` at N raises `clear_busy_o` and waitrequest at N+1.
  - Both stay high for exactly 2^HASH_W cycles, then drop together.
- Lookups in flight when `config_i` rises still complete with valid. New lookups are suppressed from the cycle `config_i`=1 is sampled.
- `srst_i` mid-clear:
  - next cycle FSM=IDLE, busy=0, all valid outputs 0, in-flight reads and lookups discarded;
  - tables are left partially cleared.

## Configuration
- `HASH_LUT_V2_OUT_REG_EN` defined: an extra register stage follows the match AND. Lookup latency becomes 3; readback latency is unchanged at 2.
- Not defined: `match_o`, `lookup_bits_o` and `match_valid_o` are driven from the 2-cycle stage, latency 2.

## Test plan
- Reset then readback of table 0 bit 5 with `config_i`=1 -> `readdatavalid` at +2, readdata=0.
- Write 1 to table 3 (str 8, hash 3) bit 0x0A5, then read it back -> readdata=1 at +2. Read of table TABLES_CNT -> readdata=0 with readdatavalid.
- Set bit 0x123 in all six str-8 tables, `config_i`=0, lookup str 8 all hashes=0x123 -> `match_o[8]`=1, others 0 at +2 (+3 with macro). Change one hash to 0x124 -> `match_o[8]`=0.
- `clear_start_i` with HASH_W=12 -> busy for exactly 4096 cycles with waitrequest=1 and writes ignored. All prior 1s read back 0 afterwards.
- `srst_i` asserted at clear cycle 100 -> busy=0 next cycle. Addresses <100 read 0; earlier-set bits ≥100 read 1.
- Same-cycle write+read -> write applied, no readdatavalid. Lookup with `config_i`=1 -> `match_valid_o` stays 0.
